// File: rtl/concat_pkg.sv
`default_nettype none
// ============================================================================
// Module   : concat_pkg
// Brief    : Shared ordering constants and chunk-offset helper for the packer.
// Revision : 1.0 - initial release
// ============================================================================
package concat_pkg;

    localparam logic ORD_LSB_FIRST = 1'b0;
    localparam logic ORD_MSB_FIRST = 1'b1;

    // Bit offset of chunk k inside the packed word for the given ordering mode.
    function automatic int chunk_lo(input int k, input logic mode,
                                    input int din_w, input int num_ch);
        return (mode == ORD_MSB_FIRST) ? (num_ch - 1 - k) * din_w : k * din_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/concat_out_reg.sv
`default_nettype none
// ============================================================================
// Module   : concat_out_reg
// Brief    : One-entry valid/ready holding register with load, drain and flush.
// Revision : 1.0 - initial release
// ============================================================================
module concat_out_reg #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_clr,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Flush drops the entry but keeps the data bits as they were.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_clr) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_data  <= i_data;
        end else if (r_valid && i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;

endmodule
`default_nettype wire

// File: rtl/concat_packer.sv
`default_nettype none
// ============================================================================
// Module   : concat_packer
// Brief    : Packs NUM_CH DIN_W-bit stream chunks into one valid/ready word.
// Revision : 1.0 - initial release
// ============================================================================
module concat_packer
    import concat_pkg::*;
#(
    parameter int DIN_W  = 4,
    parameter int NUM_CH = 2,
    parameter int DOUT_W = DIN_W * NUM_CH,
    parameter int CNT_W  = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              clr,
    input  logic              msb_first,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DIN_W-1:0]  din,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DOUT_W-1:0] dout,
    output logic [CNT_W-1:0]  fill
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(NUM_CH - 1);

    logic [CNT_W-1:0]  r_fill;
    logic [DOUT_W-1:0] r_asm;
    logic              r_mode;
    logic [DOUT_W-1:0] w_merged;
    logic              w_mode;
    logic              w_last;
    logic              w_in_xfer;
    logic              w_load;

    assign w_last    = (r_fill == c_last);
    // Only the completing chunk needs the output slot, so only it may stall.
    assign in_ready  = !(w_last && out_valid && !out_ready);
    assign w_in_xfer = in_valid && in_ready;
    assign w_load    = w_in_xfer && w_last && !clr;
    assign w_mode    = (r_fill == '0) ? msb_first : r_mode;
    assign fill      = r_fill;

    always_comb begin
        w_merged = r_asm;
        for (int s = 0; s < NUM_CH; s++) begin
            if (chunk_lo(int'(r_fill), w_mode, DIN_W, NUM_CH) == s * DIN_W) begin
                w_merged[s*DIN_W +: DIN_W] = din;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_fill <= '0;
            r_asm  <= '0;
            r_mode <= ORD_LSB_FIRST;
        end else if (clr) begin
            r_fill <= '0;
            r_asm  <= '0;
        end else if (w_in_xfer) begin
            if (w_last) begin
                r_fill <= '0;
                r_asm  <= '0;
            end else begin
                r_fill <= r_fill + 1'b1;
                r_asm  <= w_merged;
            end
            if (r_fill == '0) begin
                r_mode <= msb_first;
            end
        end
    end

    concat_out_reg #(
        .DATA_W (DOUT_W)
    ) u_out_reg (
        .clk     (clk),
        .rstn    (rstn),
        .i_clr   (clr),
        .i_load  (w_load),
        .i_data  (w_merged),
        .i_ready (out_ready),
        .o_valid (out_valid),
        .o_data  (dout)
    );

endmodule
`default_nettype wire
